// File: rtl/game_seq_pkg.sv
// game_seq_pkg: shared state encoding for the flappy-bird game sequencer and its consumers
package game_seq_pkg;
  localparam int GAME_STATE_W = 3;
  typedef enum logic [GAME_STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_WIN   = 3'd3,
    S_DEAD  = 3'd4
  } game_state_t;
endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: board/condition inputs and movement/score controls of the game sequencer
// Ports (via modports): start, flap, win, die into the sequencer; step, flap_req,
// tree_reload, score_inc, score_clr, state, level out of it.
interface game_sequencer_if #(parameter int LVL_W = 4);
  import game_seq_pkg::*;
  logic start;
  logic flap;
  logic win;
  logic die;
  logic step;
  logic flap_req;
  logic tree_reload;
  logic score_inc;
  logic score_clr;
  logic [GAME_STATE_W-1:0] state;
  logic [LVL_W-1:0] level;
  modport master (
    input  start, flap, win, die,
    output step, flap_req, tree_reload, score_inc, score_clr, state, level
  );
  modport slave (
    output start, flap, win, die,
    input  step, flap_req, tree_reload, score_inc, score_clr, state, level
  );
endinterface

// File: rtl/game_sequencer_step_timer.sv
// step_timer: step-period counter, hold-wrap counter and speed-level divisor
// Ports: clock, reset (async, active-high); en counts periods, hold counts wraps,
// clr restarts both on a state change, level selects the divisor; wrap marks the
// last cycle of a period, hold_done the last cycle of a hold.
// Build option: GAME_SEQ_SPEEDUP_EN shortens the period by DIV_STEP per level.
module step_timer #(
  parameter int TICK_DIV   = 16,
  parameter int MIN_DIV    = 4,
  parameter int DIV_STEP   = 2,
  parameter int HOLD_TICKS = 8,
  parameter int LVL_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             hold,
  input  logic             clr,
  input  logic [LVL_W-1:0] level,
  output logic             wrap,
  output logic             hold_done
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int PW = LVL_W + DW;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  logic [CW-1:0] cnt;
  logic [HW-1:0] hcnt;
  logic [DW-1:0] div;
`ifdef GAME_SEQ_SPEEDUP_EN
  logic [PW-1:0] prod;
  // Wide product so a large level saturates at MIN_DIV instead of wrapping.
  always_comb begin
    prod = PW'(level) * PW'(DIV_STEP);
    div = (prod >= PW'(TICK_DIV - MIN_DIV)) ? DW'(MIN_DIV) : DW'(PW'(TICK_DIV) - prod);
  end
`else
  logic unused_level;
  assign unused_level = ^level;
  assign div = DW'(TICK_DIV);
`endif
  assign wrap      = en && (DW'(cnt) == div - DW'(1));
  assign hold_done = hold && wrap && (hcnt == HW'(HOLD_TICKS - 1));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      cnt  <= (clr || !en || wrap) ? '0 : cnt + 1'b1;
      hcnt <= (clr || !hold) ? '0 : wrap ? hcnt + 1'b1 : hcnt;
    end
  end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: run/pause/win/death controller and movement step generator
// Ports: clock, reset (async, active-high); gs (game_sequencer_if.master) carries
// start/flap/win/die in and step, flap_req, tree_reload, score_inc, score_clr,
// state, level out.
// Build option: GAME_SEQ_SPEEDUP_EN makes the step period shrink with level.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int TICK_DIV   = 16,
  parameter int MIN_DIV    = 4,
  parameter int DIV_STEP   = 2,
  parameter int HOLD_TICKS = 8,
  parameter int LVL_W      = 4
) (
  input logic               clock,
  input logic               reset,
  game_sequencer_if.master  gs
);
  game_state_t      state_q, nxt;
  logic [LVL_W-1:0] level_q;
  logic             flap_q, tr_q, si_q, sc_q;
  logic             wrap, hold_done, counting, holding;
  logic             step, tr_d, si_d, sc_d;
  assign counting = state_q inside {S_RUN, S_WIN, S_DEAD};
  assign holding  = state_q inside {S_WIN, S_DEAD};
  step_timer #(
    .TICK_DIV(TICK_DIV), .MIN_DIV(MIN_DIV), .DIV_STEP(DIV_STEP),
    .HOLD_TICKS(HOLD_TICKS), .LVL_W(LVL_W)
  ) u_timer (
    .clock(clock), .reset(reset), .en(counting), .hold(holding),
    .clr(nxt != state_q), .level(level_q), .wrap(wrap), .hold_done(hold_done)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= nxt;
  end
  // Illegal encodings fall into default and recover to IDLE.
  always_comb begin
    nxt = S_IDLE;
    case (state_q)
      S_IDLE:  nxt = gs.start ? S_RUN : S_IDLE;
      S_RUN:   nxt = gs.die ? S_DEAD : gs.win ? S_WIN : gs.start ? S_RUN : S_PAUSE;
      S_PAUSE: nxt = gs.start ? S_RUN : S_PAUSE;
      S_WIN:   nxt = !hold_done ? S_WIN : gs.start ? S_RUN : S_PAUSE;
      S_DEAD:  nxt = hold_done ? S_IDLE : S_DEAD;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    step = (state_q == S_RUN) && wrap;
    sc_d = (state_q == S_IDLE && nxt == S_RUN) || (state_q == S_DEAD && nxt == S_IDLE);
    si_d = (state_q == S_RUN) && (nxt == S_WIN);
    tr_d = sc_d || (state_q == S_WIN && nxt != S_WIN);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tr_q    <= 1'b0;
      si_q    <= 1'b0;
      sc_q    <= 1'b0;
      flap_q  <= 1'b0;
      level_q <= '0;
    end else begin
      tr_q    <= tr_d;
      si_q    <= si_d;
      sc_q    <= sc_d;
      // Gating on the next state keeps the latch at 0 in every non-RUN cycle.
      flap_q  <= (nxt == S_RUN) && ((flap_q && !step) || gs.flap);
      level_q <= (hold_done && state_q == S_DEAD) ? '0 :
                 (hold_done && state_q == S_WIN && !(&level_q)) ? level_q + 1'b1 : level_q;
    end
  end
  assign gs.step        = step;
  assign gs.flap_req    = flap_q;
  assign gs.tree_reload = tr_q;
  assign gs.score_inc   = si_q;
  assign gs.score_clr   = sc_q;
  assign gs.state       = state_q;
  assign gs.level       = level_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed vector and sequence checks of game_sequencer
module tb_game_sequencer;
  import game_seq_pkg::*;
`ifdef GAME_SEQ_SPEEDUP_EN
  localparam int P = 3;
`else
  localparam int P = 4;
`endif
  typedef struct packed {
    logic s, f, w, d;
    logic [2:0] st;
    logic stp, fr, tr, si, sc;
    logic [3:0] lvl;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;
  game_sequencer_if #(.LVL_W(4)) gs();
  game_sequencer #(
    .TICK_DIV(4), .MIN_DIV(2), .DIV_STEP(1), .HOLD_TICKS(2), .LVL_W(4)
  ) dut (
    .clock(clk), .reset(rst), .gs(gs)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] outs();
    return {gs.state, gs.step, gs.flap_req, gs.tree_reload, gs.score_inc, gs.score_clr, gs.level};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic s, input logic f, input logic w, input logic d);
    gs.start = s;
    gs.flap  = f;
    gs.win   = w;
    gs.die   = d;
  endtask
  task automatic add(input logic s, input logic f, input logic w, input logic d,
                     input logic [2:0] st, input logic stp, input logic fr, input logic tr,
                     input logic si, input logic sc, input logic [3:0] lvl);
    tbl.push_back(vec_t'({s, f, w, d, st, stp, fr, tr, si, sc, lvl}));
  endtask
  task automatic wait_step(input string name, input int exp);
    int k = 1;
    while (!gs.step && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, k, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int h;
    add(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 4'd0);
    add(1, 1, 0, 0, 3'd1, 0, 0, 1, 0, 1, 4'd0);
    add(1, 0, 0, 0, 3'd1, 0, 1, 0, 0, 0, 4'd0);
    add(1, 0, 0, 0, 3'd1, 0, 1, 0, 0, 0, 4'd0);
    add(1, 0, 0, 0, 3'd1, 1, 1, 0, 0, 0, 4'd0);
    add(1, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 4'd0);
    add(1, 0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 4'd0);
    add(1, 0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 4'd0);
    add(1, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0, 4'd0);
    add(1, 0, 0, 0, 3'd3, 0, 0, 0, 1, 0, 4'd0);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0, 4'd0);
    add(1, 0, 0, 0, 3'd1, 0, 0, 1, 0, 0, 4'd1);
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset state", outs(), 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("vector %0d", i), outs(),
          {tbl[i].st, tbl[i].stp, tbl[i].fr, tbl[i].tr, tbl[i].si, tbl[i].sc, tbl[i].lvl});
      drive(tbl[i].s, tbl[i].f, tbl[i].w, tbl[i].d);
    end
    wait_step("level1 first step", P);
    @(negedge clk);
    wait_step("level1 step period", P);
    drive(1, 0, 1, 1);
    @(negedge clk);
    chk("win+die state", gs.state, 3'd4);
    chk("win+die score_inc", gs.score_inc, 0);
    drive(0, 0, 0, 0);
    h = 0;
    while (gs.state == 3'd4 && h < 40) begin
      h++;
      @(negedge clk);
    end
    chk("dead hold length", h, 2 * P);
    chk("dead exit outputs", outs(), {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0});
    @(negedge clk);
    chk("idle stays", outs(), 0);
    drive(1, 0, 0, 0);
    @(negedge clk);
    chk("restart outputs", outs(), {3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0});
    repeat (2) @(negedge clk);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("pause entry", outs(), {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    @(negedge clk);
    chk("pause held", outs(), {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    drive(1, 0, 0, 0);
    @(negedge clk);
    chk("resume no pulses", outs(), {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    wait_step("resume first step", 4);
    drive(1, 0, 1, 0);
    @(negedge clk);
    chk("win entry", {gs.state, gs.score_inc}, {3'd3, 1'b1});
    drive(1, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async reset mid-hold", outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("run after reset", outs(), {3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the LED-matrix flappy-bird game. It owns the run/pause/win/death state machine and generates the single-cycle `step` enable that advances bird and tree movement. It issues the score and tree-reload pulses that the bird-movement, trees and win-counter blocks consume. It sits between the board inputs (start switch, flap key) and the `win`/`die` conditions, all on one divided game clock.

## Interface
- `TICK_DIV`, 16: clock cycles per `step` at level 0; must be ≥ 2.
- `MIN_DIV`, 4: fastest allowed step period; 2 ≤ `MIN_DIV` ≤ `TICK_DIV`.
- `DIV_STEP`, 2: period reduction per level.
- `HOLD_TICKS`, 8: step periods spent in a win/death hold; ≥ 1.
- `LVL_W`, 4: level counter width.

Ports:
- `clock` in 1: game clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: run enable, from `SW[0]`; 1 runs, 0 pauses. Synchronous to `clock`.
- `flap` in 1: flap request, active high (inverted `KEY[3]`).
- `win` in 1: round-won condition, sampled each cycle.
- `die` in 1: death condition, sampled each cycle.
- `step` out 1: one-cycle movement enable.
- `flap_req` out 1: latched flap; valid whenever `step`=1.
- `tree_reload` out 1: one-cycle pulse; trees reload their patterns.
- `score_inc` out 1: one-cycle pulse; score +1.
- `score_clr` out 1: one-cycle pulse; score to 0.
- `state` out 3: current state encoding.
- `level` out `LVL_W`: current speed level.

## Operation
States: IDLE=0, RUN=1, PAUSE=2, WIN_HOLD=3, DEAD_HOLD=4. Encodings 5–7 are illegal and recover to IDLE on the next edge.

Transitions:
- **IDLE:** `start`=1 → RUN.
- **RUN:** the first matching condition wins:
  - `die` → DEAD_HOLD. `die` beats `win` when both are high.
  - `win` → WIN_HOLD.
  - `start`=0 → PAUSE.
- **PAUSE:** `start`=1 → RUN. `win`/`die` are ignored.
- **WIN_HOLD:** after `HOLD_TICKS` period wraps:
  - `level` increments, saturating at 2^`LVL_W`−1.
  - Next state is RUN if `start`=1, else PAUSE.
- **DEAD_HOLD:** after `HOLD_TICKS` period wraps:
  - `level` clears to 0.
  - Next state is IDLE.

Pulses are registered and high for exactly the first cycle in the new state:
- `score_clr` + `tree_reload`: on entry to RUN from IDLE, and on entry to IDLE from DEAD_HOLD.
- `score_inc`: on entry to WIN_HOLD.
- `tree_reload`: on exit from WIN_HOLD.
- RUN↔PAUSE transitions produce no pulses.

Period counter `cnt`:
- Width is `$clog2(TICK_DIV)`.
- It clears to 0 on every state change.
- It counts 0..`div`−1 and wraps in RUN, WIN_HOLD and DEAD_HOLD.
- It holds at 0 in IDLE and PAUSE.

Step generation:
- `step` = (state==RUN) && (`cnt`==`div`−1). It is decoded from registers only.
- In the hold states the wraps are counted by a hold counter of width `$clog2(HOLD_TICKS+1)`, and no `step` is emitted.

Divisor `div`:
- Computed with `SPEEDUP_EN` as described under Configuration.
- Without it, `div` = `TICK_DIV`.

Flap latch:
- Update rule: `flap_req` <= (`flap_req` & ~`step`) | `flap`.
- It is forced to 0 outside RUN.
- A one-cycle press between steps is therefore held until the cycle after the next `step`.

## Timing
- **Reset:** asynchronous assertion drives the block to its reset state immediately, including mid-hold or mid-period.
  - `state`=IDLE, `cnt`=0, hold counter 0, `level`=0.
  - `step`, `flap_req`, `tree_reload`, `score_inc`, `score_clr` all 0.
- **First step:** entering RUN at edge E puts the first `step` in cycle E+`div`−1, i.e. the `div`-th RUN cycle. Steps then repeat every `div` cycles.
- **Win/die latency:** `win`/`die` high in RUN cycle N moves `state` at edge N+1, with the pulse high in cycle N+1. A `step` in cycle N is still delivered.
- **Hold length:** exactly `HOLD_TICKS`×`div` cycles. `div` is frozen at its value on hold entry.
- **Level change:** `level` takes its new value in the first cycle after hold exit, so the new `div` applies from that RUN entry.

## Configuration
- `GAME_SEQ_SPEEDUP_EN` defined: `div` = max(`MIN_DIV`, `TICK_DIV` − `level`×`DIV_STEP`).
  - The product is computed at width `LVL_W`+`$clog2(TICK_DIV+1)`, so it cannot underflow.
- Not defined: `div` = `TICK_DIV` at every level. `level` still counts, for display.

## Structure
- `game_seq_pkg` holds:
  - `typedef enum logic [2:0] game_state_t` with S_IDLE, S_RUN, S_PAUSE, S_WIN, S_DEAD;
  - localparam `GAME_STATE_W`=3.
- The trees, birdwin and wincounter blocks import the package for `state` decoding.
- Sub-module `step_timer` contains:
  - the `div` computation;
  - `cnt`;
  - the hold counter, which outputs `wrap` and `hold_done`.
- The FSM, pulse registers and flap latch stay in `game_sequencer`.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `MIN_DIV`=2, `DIV_STEP`=1, `HOLD_TICKS`=2.
1. Reset, then `start`=1 → `state`=1 next cycle with `score_clr`=`tree_reload`=1 for that one cycle; `step` in the 4th, 8th and 12th RUN cycles.
2. `flap` pulsed one cycle at RUN cycle 1 → `flap_req`=1 through cycle 4, where `step`=1; 0 in cycle 5.
3. `win` pulse in RUN:
   - `score_inc` for 1 cycle and `state`=3;
   - no `step` for 8 cycles, then `state`=1 with `tree_reload` and `level`=1;
   - step period 3 with `GAME_SEQ_SPEEDUP_EN`, 4 without.
4. `win`=`die`=1 same cycle → `state`=4 and no `score_inc`. After 8 cycles: `score_clr`=`tree_reload`=1, `state`=0, `level`=0.
5. `start`=0 in RUN at `cnt`=2 → PAUSE with no `step`. `start`=1 → RUN, first `step` 4 cycles later.
6. `reset` asserted mid-WIN_HOLD, off-edge → outputs at reset values before the next clock edge; `state`=0.
